// File: rtl/register_file.sv
// Architectural register file with per-register rename tracking (busy flag + producing ROB tag).
// Optional commit trace counter/print enabled by defining REGFILE_TRACE_EN.
module register_file #(
  parameter int ROB_SIZE_BIT = 4,
  parameter int REG_NUM      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic [4:0]              rob_set_idx,
  input  logic [31:0]             rob_set_reg_val,
  input  logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
  input  logic [4:0]              rf_set_idx,
  input  logic [ROB_SIZE_BIT-1:0] rf_set_dep,
  input  logic [4:0]              rs1_idx,
  output logic [31:0]             rs1_val,
  output logic                    rs1_busy,
  output logic [ROB_SIZE_BIT-1:0] rs1_dep,
  input  logic [4:0]              rs2_idx,
  output logic [31:0]             rs2_val,
  output logic                    rs2_busy,
  output logic [ROB_SIZE_BIT-1:0] rs2_dep
`ifdef REGFILE_TRACE_EN
  ,
  output logic [31:0]             dbg_write_cnt
`endif
);

  logic [REG_NUM-1:0][31:0]             val_reg, val_next;
  logic [REG_NUM-1:0]                   busy_reg, busy_next;
  logic [REG_NUM-1:0][ROB_SIZE_BIT-1:0] dep_reg, dep_next;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign val_next[gi]  = '0;
        assign busy_next[gi] = 1'b0;
        assign dep_next[gi]  = '0;
      end else begin : g_live
        logic commit_hit;
        logic release_hit;
        logic rename_hit;

        assign commit_hit  = (rob_set_idx == 5'(gi));
        // Only the producer that still owns the register may release it.
        assign release_hit = commit_hit && busy_reg[gi] && (dep_reg[gi] == rob_set_recorder);
        assign rename_hit  = (rf_set_idx == 5'(gi));

        assign val_next[gi] = commit_hit ? rob_set_reg_val : val_reg[gi];

        always_comb begin
          busy_next[gi] = busy_reg[gi];
          dep_next[gi]  = dep_reg[gi];
          if (clear) begin
            busy_next[gi] = 1'b0;
            dep_next[gi]  = '0;
          end else if (rename_hit) begin
            busy_next[gi] = 1'b1;
            dep_next[gi]  = rf_set_dep;
          end else if (release_hit) begin
            busy_next[gi] = 1'b0;
            dep_next[gi]  = '0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_reg  <= '0;
      busy_reg <= '0;
      dep_reg  <= '0;
    end else if (rdy_in) begin
      val_reg  <= val_next;
      busy_reg <= busy_next;
      dep_reg  <= dep_next;
    end
  end

  // Read ports: a same-cycle owning commit is forwarded; renames are never forwarded.
  logic [1:0][4:0]              rd_idx;
  logic [1:0]                   rd_hit;
  logic [1:0][31:0]             rd_val;
  logic [1:0]                   rd_busy;
  logic [1:0][ROB_SIZE_BIT-1:0] rd_dep;

  assign rd_idx[0] = rs1_idx;
  assign rd_idx[1] = rs2_idx;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_hit[gi]  = rdy_in && (rd_idx[gi] != 5'd0) && (rob_set_idx == rd_idx[gi]) &&
                           busy_reg[rd_idx[gi]] && (dep_reg[rd_idx[gi]] == rob_set_recorder);
      assign rd_val[gi]  = rd_hit[gi] ? rob_set_reg_val : val_reg[rd_idx[gi]];
      assign rd_busy[gi] = rd_hit[gi] ? 1'b0 : busy_reg[rd_idx[gi]];
      assign rd_dep[gi]  = rd_hit[gi] ? '0 : dep_reg[rd_idx[gi]];
    end
  endgenerate

  assign rs1_val  = rd_val[0];
  assign rs1_busy = rd_busy[0];
  assign rs1_dep  = rd_dep[0];
  assign rs2_val  = rd_val[1];
  assign rs2_busy = rd_busy[1];
  assign rs2_dep  = rd_dep[1];

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dbg_write_cnt <= '0;
    end else if (rdy_in && rob_set_idx != 5'd0) begin
      dbg_write_cnt <= dbg_write_cnt + 32'd1;
      $display("reg[%0d] = %h", rob_set_idx, rob_set_reg_val);
    end
  end
`endif

endmodule
